// File: rtl/adder_tb_pkg.sv
// rtl/adder_tb_pkg.sv - shared types and constants for the 4-bit adder scoreboard
package adder_tb_pkg;

  localparam int CNT_W       = 16;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } chk_state_t;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adder_chk_delay.sv
// rtl/adder_chk_delay.sv - LATENCY-deep alignment pipe for {valid, a, b}
module adder_chk_delay
  import adder_tb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam int W = 1 + 2 * WIDTH;

  logic [W-1:0] stages [LATENCY];

  // Free-running shift register; it never stalls so stimulus stays aligned with the sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stages[i] <= '0;
    end else begin
      stages[0] <= {valid_in, a_in, b_in};
      for (int i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign {valid_out, a_out, b_out} = stages[LATENCY-1];

endmodule

// File: rtl/adder4b_checker.sv
// rtl/adder4b_checker.sv - aligns DUT/reference sums to stimulus, compares and counts
module adder4b_checker
  import adder_tb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int NUM_VECTORS = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH:0]   dut_sum,
  input  logic [WIDTH:0]   ref_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_pulse,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_dut,
  output logic [WIDTH:0]   first_err_ref
);

  localparam logic [CNT_W:0] NUM_V     = (CNT_W+1)'(NUM_VECTORS);
  localparam bit             STOP_ERR  = (STOP_ON_ERR != 0);

  chk_state_t       state;
  logic             d_valid;
  logic [WIDTH-1:0] d_a;
  logic [WIDTH-1:0] d_b;
  logic             is_match;
  logic [CNT_W:0]   total_next;
  logic             hit_end;

  adder_chk_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (enable_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .valid_out (d_valid),
    .a_out     (d_a),
    .b_out     (d_b)
  );

  // Full-width compare, carry bit included
  assign is_match   = (dut_sum == ref_sum);
  // Vectors compared so far including the one in this slot; one extra bit avoids wrap
  assign total_next = {1'b0, match_cnt} + {1'b0, mismatch_cnt} + 1'b1;
  assign hit_end    = (total_next == NUM_V);

  // Run-control FSM with counters, first-error capture and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      match_cnt       <= '0;
      mismatch_cnt    <= '0;
      err_pulse       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_dut   <= '0;
      first_err_ref   <= '0;
    end else begin
      err_pulse <= 1'b0;
      // Status follows the state held before this edge, so it lags the transition by a cycle
      busy      <= (state == RUN);
      done      <= (state == DONE) || (state == FAIL);
      pass      <= (state == DONE) && (mismatch_cnt == '0);

      case (state)
        IDLE, DONE, FAIL: begin
          // A slot coinciding with start belongs to the old run and is dropped here
          if (start) begin
            state           <= RUN;
            match_cnt       <= '0;
            mismatch_cnt    <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_dut   <= '0;
            first_err_ref   <= '0;
          end
        end
        RUN: begin
          if (d_valid) begin
            if (is_match) begin
              match_cnt <= sat_inc(match_cnt);
            end else begin
              mismatch_cnt <= sat_inc(mismatch_cnt);
              err_pulse    <= 1'b1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= d_a;
                first_err_b     <= d_b;
                first_err_dut   <= dut_sum;
                first_err_ref   <= ref_sum;
              end
            end
            // Stop-on-error wins over reaching the vector count in the same slot
            if (!is_match && STOP_ERR) begin
              state <= FAIL;
            end else if (hit_end) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
